square_wave_meter: RTL and testbench



---
 rtl/square_wave_meter.sv | 140 ++++++++++++++
 tb/tb_square_wave_meter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_meter.sv
// Measures the high time, low time and period of each complete cycle of an
// asynchronous square wave, in clk cycles. Results appear together with a one-cycle meas_valid.
module square_wave_meter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  output logic [N-1:0] high_time,
  output logic [N-1:0] low_time,
  output logic [N:0]   period,
  output logic         meas_valid,
  output logic         ovf
);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = N'(1);

  state_t       state, state_nxt;
  logic         sync1, s, prev;
  logic [1:0]   warm;
  logic         rise, fall;
  logic [N-1:0] cnt, hold_hi;
  logic         hi_ovf, lo_ovf, hold_ovf;

  // FSM control decodes
  logic start_cnt, inc_hi, inc_lo, latch_hi, publish;

  // The synchronizer flops reset to 0, so s only shows the real pin level two
  // edges after reset. warm marks that point so IDLE cannot arm on a fake low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      prev  <= 1'b0;
      warm  <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values;
      // blocking ones here would collapse the synchronizer into a single stage.
      sync1 <= sig_in;
      s     <= sync1;
      prev  <= s;
      warm  <= {warm[0], 1'b1};
    end
  end

  assign rise = s & ~prev;
  assign fall = ~s & prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:  if (warm[1] && !s) state_nxt = ARMED;
      ARMED: if (rise)          state_nxt = HIGH;
      HIGH:  if (fall)          state_nxt = LOW;
      LOW:   if (rise)          state_nxt = HIGH;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_cnt = 1'b0;
    inc_hi    = 1'b0;
    inc_lo    = 1'b0;
    latch_hi  = 1'b0;
    publish   = 1'b0;
    case (state)
      ARMED: start_cnt = rise;
      HIGH: begin
        start_cnt = fall;
        latch_hi  = fall;
        inc_hi    = s;
      end
      LOW: begin
        start_cnt = rise;
        publish   = rise;
        inc_lo    = ~s;
      end
      default: ;
    endcase
  end

  // Phase counter and overflow flags; a new phase always begins at 1 so the
  // edge cycle itself is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      hi_ovf <= 1'b0;
      lo_ovf <= 1'b0;
    end else if (start_cnt) begin
      cnt <= CNT_ONE;
      if (state != HIGH) begin
        hi_ovf <= 1'b0;
        lo_ovf <= 1'b0;
      end
    end else if (inc_hi || inc_lo) begin
      if (cnt != CNT_MAX) cnt    <= cnt + CNT_ONE;
      else if (inc_hi)    hi_ovf <= 1'b1;
      else                lo_ovf <= 1'b1;
    end
  end

  // High result waits here until the closing rise publishes the full cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_hi  <= '0;
      hold_ovf <= 1'b0;
    end else if (latch_hi) begin
      hold_hi  <= cnt;
      hold_ovf <= hi_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_time  <= '0;
      low_time   <= '0;
      period     <= '0;
      ovf        <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= publish;
      if (publish) begin
        high_time <= hold_hi;
        low_time  <= cnt;
        period    <= (N+1)'(hold_hi) + (N+1)'(cnt);
        ovf       <= hold_ovf | lo_ovf;
      end
    end
  end

endmodule

// File: tb/tb_square_wave_meter.sv
// Self-checking bench for square_wave_meter: directed and random phase sequences
// against a phase-length reference model, compared measurement by measurement.
module tb_square_wave_meter;

  localparam int N   = 4;
  localparam int MAX = (1 << N) - 1;

  typedef struct {
    int h;
    int l;
    int p;
    int o;
    int stamp;
  } meas_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig_in = 1'b0;
  logic [N-1:0] high_time, low_time;
  logic [N:0]   period;
  logic         meas_valid, ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  meas_t exp_q[$];
  meas_t got_q[$];

  // Reference model state: lengths of the current high/low phases in clk cycles
  bit seen_low  = 1'b0;
  bit have_high = 1'b0;
  int hlen      = 0;
  int llen      = 0;

  square_wave_meter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .high_time  (high_time),
    .low_time   (low_time),
    .period     (period),
    .meas_valid (meas_valid),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (meas_valid === 1'b1)
      got_q.push_back('{int'(high_time), int'(low_time), int'(period), int'(ovf), cyc});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one phase of lv for k cycles, starting 1 time unit after a rising edge.
  // A rise that ends a fully seen high+low pair must be reported 3 edges later.
  task automatic phase(input bit lv, input int k);
    int hs, ls;
    if (lv && !sig_in) begin
      if (have_high) begin
        hs = (hlen > MAX) ? MAX : hlen;
        ls = (llen > MAX) ? MAX : llen;
        exp_q.push_back('{hs, ls, hs + ls, int'(hlen > MAX || llen > MAX), cyc + 3});
      end
      have_high = seen_low;
      hlen = 0;
    end else if (!lv && sig_in) begin
      llen = 0;
    end
    sig_in = lv;
    if (lv) hlen += k;
    else begin
      llen += k;
      seen_low = 1'b1;
    end
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_high"},  high_time,  0);
    check({tag, "_low"},   low_time,   0);
    check({tag, "_per"},   period,     0);
    check({tag, "_valid"}, meas_valid, 0);
    check({tag, "_ovf"},   ovf,        0);
  endtask

  // Holds rst for k cycles; outputs must clear at once, before any clock edge.
  task automatic reset_pulse(input string tag, input int k);
    rst = 1'b1;
    #1;
    check_zero(tag);
    repeat (k) @(posedge clk);
    #1;
    rst = 1'b0;
    have_high = 1'b0;
    seen_low  = !sig_in;
    hlen = 0;
    llen = 0;
  endtask

  task automatic check_meas(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]_high",  tag, i), got_q[i].h,     exp_q[i].h);
      check($sformatf("%s[%0d]_low",   tag, i), got_q[i].l,     exp_q[i].l);
      check($sformatf("%s[%0d]_per",   tag, i), got_q[i].p,     exp_q[i].p);
      check($sformatf("%s[%0d]_ovf",   tag, i), got_q[i].o,     exp_q[i].o);
      check($sformatf("%s[%0d]_cycle", tag, i), got_q[i].stamp, exp_q[i].stamp);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic int rand_len();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(16, 24));
    return int'($urandom_range(1, 14));
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    seen_low = 1'b1;

    // Generator loopback 5 on / 3 off
    phase(0, 5);
    repeat (4) begin
      phase(1, 5);
      phase(0, 3);
    end
    phase(1, 5);
    phase(0, 6);
    check_meas("loop53");

    // Minimum period 1/1
    repeat (8) begin
      phase(1, 1);
      phase(0, 1);
    end
    phase(1, 4);
    phase(0, 6);
    check_meas("min11");

    // High phase saturates, next cycle is clean
    phase(1, 20);
    phase(0, 3);
    phase(1, 5);
    phase(0, 3);
    phase(1, 5);
    phase(0, 6);
    check_meas("sat");

    // Reset in the middle of a low phase
    phase(1, 5);
    phase(0, 3);
    reset_pulse("rst_low", 1);
    phase(0, 5);
    phase(1, 5);
    phase(0, 3);
    phase(1, 5);
    phase(0, 6);
    check_meas("rst_low");

    // sig_in high through and after reset release
    phase(1, 4);
    reset_pulse("rst_high", 3);
    phase(1, 5);
    phase(0, 4);
    phase(1, 6);
    phase(0, 2);
    phase(1, 5);
    phase(0, 6);
    check_meas("rst_high");

    // DC input after a 5/3 measurement
    phase(1, 5);
    phase(0, 3);
    phase(1, 100);
    phase(0, 100);
    check_meas("dc");
    check("dc_hold_high",  high_time,  5);
    check("dc_hold_low",   low_time,   3);
    check("dc_hold_per",   period,     8);
    check("dc_hold_ovf",   ovf,        0);
    check("dc_hold_valid", meas_valid, 0);

    // Random phase lengths
    repeat (40) begin
      phase(1, rand_len());
      phase(0, rand_len());
    end
    phase(1, 5);
    phase(0, 6);
    check_meas("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
